// File: rtl/sequence_control_pkg.sv
// Shared constants for the sequence controller: state encodings, start-code values and the classifier.
// ST_ERROR exists only when SEQUENCE_CONTROL_TIMEOUT_EN is defined.
package sequence_control_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RESET    = 3'd1;
  localparam logic [2:0] ST_FILL     = 3'd2;
  localparam logic [2:0] ST_WAIT_ADV = 3'd3;
  localparam logic [2:0] ST_HEADERS  = 3'd4;
  localparam logic [2:0] ST_RUN      = 3'd5;
`ifdef SEQUENCE_CONTROL_TIMEOUT_EN
  localparam logic [2:0] ST_ERROR    = 3'd6;
`endif

  localparam logic [7:0] PICTURE_SC  = 8'h00;
  localparam logic [7:0] SLICE_FIRST = 8'h01;
  localparam logic [7:0] SLICE_LAST  = 8'hAF;
  localparam logic [7:0] SEQ_HDR_SC  = 8'hB3;
  localparam logic [7:0] SEQ_END_SC  = 8'hB7;

  typedef struct packed {
    logic startCode;
    logic picture;
    logic slice;
    logic seqHeader;
    logic seqEnd;
  } sc_flags_t;

  // A start code is the 0x000001 prefix; the low byte selects the kind.
  function automatic sc_flags_t classify(input logic [31:0] w);
    sc_flags_t f;
    f.startCode = (w[31:9] == 23'd0) && w[8];
    f.picture   = f.startCode && (w[7:0] == PICTURE_SC);
    f.slice     = f.startCode && (w[7:0] >= SLICE_FIRST) && (w[7:0] <= SLICE_LAST);
    f.seqHeader = f.startCode && (w[7:0] == SEQ_HDR_SC);
    f.seqEnd    = f.startCode && (w[7:0] == SEQ_END_SC);
    return f;
  endfunction

endpackage

// File: rtl/sequence_control_if.sv
// Handshake bundle between the sequence controller (master) and the header/picture decoders (slave).
interface sequence_control_if;

  logic Headers_Shift_1_En_I;
  logic Headers_Shift_8_En_I;
  logic Picture_Shift_1_En_I;
  logic Picture_Shift_8_En_I;
  logic Headers_Done_I;
  logic Picture_Done_I;
  logic Headers_Start_O;
  logic Picture_Start_O;

  modport master (
    input  Headers_Shift_1_En_I, Headers_Shift_8_En_I,
    input  Picture_Shift_1_En_I, Picture_Shift_8_En_I,
    input  Headers_Done_I, Picture_Done_I,
    output Headers_Start_O, Picture_Start_O
  );

  modport slave (
    output Headers_Shift_1_En_I, Headers_Shift_8_En_I,
    output Picture_Shift_1_En_I, Picture_Shift_8_En_I,
    output Headers_Done_I, Picture_Done_I,
    input  Headers_Start_O, Picture_Start_O
  );

endinterface

// File: rtl/seq_start_code_detect.sv
// Combinational start-code classifier over the top 32 bits of the bitstream window.
module seq_start_code_detect
  import sequence_control_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_window,
  output sc_flags_t             o_flags
);

  assign o_flags = classify(i_window[DATA_WIDTH-1 -: 32]);

endmodule

// File: rtl/sequence_control.sv
// Top-level sequence controller: pipe fill, frame pacing, decoder handshakes and picture counting.
// Optional watchdog/ERROR state enabled by defining SEQUENCE_CONTROL_TIMEOUT_EN.
module sequence_control
  import sequence_control_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FILL_WAIT      = 28,
  parameter int FILL_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  Start_Sequence_Decode_I,
  input  logic                  Advance_Frame_I,
  input  logic                  Free_Run_I,
  input  logic [DATA_WIDTH-1:0] Bitstream_Data_I,
  input  logic                  Shift_Busy_I,
  sequence_control_if.master    bus,
  output logic                  Shift_1_En_O,
  output logic                  Shift_8_En_O,
  output logic                  Start_Code_O,
  output logic                  Slice_Start_Code_O,
  output logic                  Picture_Start_Code_O,
  output logic                  Sequence_Header_Code_O,
  output logic                  Sequence_End_Code_O,
  output logic [15:0]           Picture_Count_O,
  output logic                  Sequence_End_O,
  output logic                  Error_O,
  output logic [2:0]            State_O
);

  localparam int FILL_LAST = FILL_WAIT + FILL_BYTES - 1;
  localparam int CW        = $clog2(FILL_WAIT + FILL_BYTES + 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_pending;
  logic          r_headersStart;
  logic          r_pictureStart;
  logic          r_seqEnd;
  logic [15:0]   r_picCount;
  sc_flags_t     w_flags;
  logic          w_fillShift;

  seq_start_code_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_detect (
    .i_window (Bitstream_Data_I),
    .o_flags  (w_flags)
  );

  assign w_fillShift = (r_state == ST_FILL) && (r_count >= CW'(FILL_WAIT)) && !Shift_Busy_I;

`ifdef SEQUENCE_CONTROL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] r_wdog;
  logic           r_error;
  logic           w_exit;
  logic           w_wdogHit;

  assign w_exit = ((r_state == ST_HEADERS) && !r_headersStart && bus.Headers_Done_I) ||
                  ((r_state == ST_RUN) && !r_pictureStart && bus.Picture_Done_I);
  assign w_wdogHit = ((r_state == ST_HEADERS) || (r_state == ST_RUN)) && !w_exit &&
                     (r_wdog == WDW'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts whenever HEADERS or RUN is entered afresh.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wdog <= '0;
    end else if (((r_state == ST_HEADERS) || (r_state == ST_RUN)) && !w_exit &&
                 !Start_Sequence_Decode_I) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  assign Error_O = r_error;
`else
  assign Error_O = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_pending      <= 1'b0;
      r_headersStart <= 1'b0;
      r_pictureStart <= 1'b0;
      r_seqEnd       <= 1'b0;
      r_picCount     <= 16'd0;
`ifdef SEQUENCE_CONTROL_TIMEOUT_EN
      r_error        <= 1'b0;
`endif
    end else begin
      r_headersStart <= 1'b0;
      r_seqEnd       <= 1'b0;
      if (Start_Sequence_Decode_I) begin
        r_state        <= ST_RESET;
        r_count        <= '0;
        r_pending      <= 1'b0;
        r_pictureStart <= 1'b0;
        r_picCount     <= 16'd0;
`ifdef SEQUENCE_CONTROL_TIMEOUT_EN
        r_error        <= 1'b0;
`endif
      end else begin
        // One-deep pacing latch; a pulse while already pending is dropped.
        if (Advance_Frame_I && (r_state != ST_IDLE) && (r_state != ST_RESET))
          r_pending <= 1'b1;
        case (r_state)
          ST_RESET: begin
            r_state <= ST_FILL;
            r_count <= '0;
          end
          ST_FILL: begin
            if (r_count < CW'(FILL_WAIT)) begin
              r_count <= r_count + 1'b1;
            end else if (!Shift_Busy_I) begin
              if (r_count == CW'(FILL_LAST)) r_state <= ST_WAIT_ADV;
              else                           r_count <= r_count + 1'b1;
            end
          end
          ST_WAIT_ADV: begin
            if (w_flags.seqEnd) begin
              r_seqEnd <= 1'b1;
              r_state  <= ST_IDLE;
            end else if (r_pending || Free_Run_I) begin
              r_headersStart <= 1'b1;
              r_pending      <= 1'b0;
              r_state        <= ST_HEADERS;
            end
          end
          ST_HEADERS: begin
            // Done seen during the start-pulse cycle may be stale from the last picture.
            if (!r_headersStart && bus.Headers_Done_I) begin
              r_pictureStart <= 1'b1;
              r_state        <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (r_pictureStart && !bus.Picture_Done_I)
              r_pictureStart <= 1'b0;
            if (!r_pictureStart && bus.Picture_Done_I) begin
              r_picCount <= r_picCount + 16'd1;
              r_state    <= ST_WAIT_ADV;
            end
          end
`ifdef SEQUENCE_CONTROL_TIMEOUT_EN
          ST_ERROR: ;
`endif
          ST_IDLE: ;
          default: r_state <= ST_IDLE;
        endcase
`ifdef SEQUENCE_CONTROL_TIMEOUT_EN
        if (w_wdogHit) begin
          r_error        <= 1'b1;
          r_pictureStart <= 1'b0;
          r_state        <= ST_ERROR;
        end
`endif
      end
    end
  end

  assign bus.Headers_Start_O = r_headersStart;
  assign bus.Picture_Start_O = r_pictureStart;

  assign Shift_1_En_O = bus.Headers_Shift_1_En_I | bus.Picture_Shift_1_En_I;
  assign Shift_8_En_O = bus.Headers_Shift_8_En_I | bus.Picture_Shift_8_En_I | w_fillShift;

  assign Start_Code_O           = w_flags.startCode;
  assign Slice_Start_Code_O     = w_flags.slice;
  assign Picture_Start_Code_O   = w_flags.picture;
  assign Sequence_Header_Code_O = w_flags.seqHeader;
  assign Sequence_End_Code_O    = w_flags.seqEnd;

  assign Picture_Count_O = r_picCount;
  assign Sequence_End_O  = r_seqEnd;
  assign State_O         = r_state;

endmodule

// File: tb/tb_sequence_control.sv
// Directed self-checking bench for sequence_control; the watchdog scenario runs only with SEQUENCE_CONTROL_TIMEOUT_EN.
module tb_sequence_control;

  localparam logic [2:0] S_IDLE = 3'd0, S_RESET = 3'd1, S_FILL = 3'd2, S_WAIT = 3'd3,
                         S_HDR = 3'd4, S_RUN = 3'd5, S_ERR = 3'd6;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, adv, freeRun, busy;
  logic [31:0] data;
  logic        picAuto, picDone;
  logic        shift1, shift8, scFlag, sliceFlag, picFlag, hdrFlag, endFlag;
  logic [15:0] picCount;
  logic        seqEnd, errFlag;
  logic [2:0]  state;

  int checks = 0;
  int fails  = 0;

  sequence_control_if bus ();

  sequence_control #(
    .DATA_WIDTH     (32),
    .FILL_WAIT      (28),
    .FILL_BYTES     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock                   (clock),
    .resetn                  (resetn),
    .Start_Sequence_Decode_I (start),
    .Advance_Frame_I         (adv),
    .Free_Run_I              (freeRun),
    .Bitstream_Data_I        (data),
    .Shift_Busy_I            (busy),
    .bus                     (bus),
    .Shift_1_En_O            (shift1),
    .Shift_8_En_O            (shift8),
    .Start_Code_O            (scFlag),
    .Slice_Start_Code_O      (sliceFlag),
    .Picture_Start_Code_O    (picFlag),
    .Sequence_Header_Code_O  (hdrFlag),
    .Sequence_End_Code_O     (endFlag),
    .Picture_Count_O         (picCount),
    .Sequence_End_O          (seqEnd),
    .Error_O                 (errFlag),
    .State_O                 (state)
  );

  always #5 clock = ~clock;

  // Picture decoder model: in auto mode it acknowledges the start and finishes the next cycle.
  assign bus.Picture_Done_I = picAuto ? ~bus.Picture_Start_O : picDone;

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout state=%0d", state);
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic waitState(input logic [2:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (state === s) break;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 0; adv = 0; freeRun = 0; busy = 0; data = 32'd0;
    picAuto = 0; picDone = 0;
    bus.Headers_Shift_1_En_I = 0; bus.Headers_Shift_8_En_I = 0;
    bus.Picture_Shift_1_En_I = 0; bus.Picture_Shift_8_En_I = 0;
    bus.Headers_Done_I = 0;
    repeat (3) @(negedge clock);
    checks++; if (state !== S_IDLE) begin fails++; $display("[TB] FAIL reset_state got=%0d exp=%0d", state, S_IDLE); end
    checks++; if (picCount !== 16'd0) begin fails++; $display("[TB] FAIL reset_count got=%0d exp=0", picCount); end
    checks++; if ({bus.Headers_Start_O, bus.Picture_Start_O, seqEnd, errFlag, shift8} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_outputs got=%b exp=00000",
                        {bus.Headers_Start_O, bus.Picture_Start_O, seqEnd, errFlag, shift8});
    end
    resetn = 1'b1;
  endtask

  // Busy is held on fill samples 30 and 31, so the four shifts land on samples 29, 32, 33, 34.
  task automatic test_fill;
    int shifts = 0, firstShift = -1, waitAt = -1;
    @(negedge clock) start = 1;
    @(negedge clock) start = 1;
    @(negedge clock) start = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      busy = (n == 30) || (n == 31);
      #1;
      if (n == 1) begin
        checks++; if (state !== S_FILL) begin fails++; $display("[TB] FAIL fill_entry got=%0d exp=%0d", state, S_FILL); end
      end
      if (state === S_WAIT) begin waitAt = n; break; end
      if (shift8 === 1'b1) begin
        shifts++;
        if (firstShift < 0) firstShift = n;
      end
    end
    busy = 0;
    checks++; if (shifts != 4) begin fails++; $display("[TB] FAIL fill_shift_count got=%0d exp=4", shifts); end
    checks++; if (firstShift != 29) begin fails++; $display("[TB] FAIL fill_first_shift got=%0d exp=29", firstShift); end
    checks++; if (waitAt != 35) begin fails++; $display("[TB] FAIL fill_wait_adv got=%0d exp=35", waitAt); end
    repeat (3) @(negedge clock);
    checks++; if (state !== S_WAIT) begin fails++; $display("[TB] FAIL wait_holds got=%0d exp=%0d", state, S_WAIT); end
  endtask

  task automatic test_classify;
    logic [31:0] vecs [6] = '{32'h000001B3, 32'h000001AF, 32'h000001B0,
                              32'h00000100, 32'h000001B7, 32'h000003B3};
    logic [4:0]  exps [6] = '{5'b10010, 5'b10100, 5'b10000, 5'b11000, 5'b10001, 5'b00000};
    logic [4:0]  got;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      data = vecs[i];
      #1;
      got = {scFlag, picFlag, sliceFlag, hdrFlag, endFlag};
      checks++;
      if (got !== exps[i]) begin
        fails++; $display("[TB] FAIL classify_%h got=%b exp=%b", vecs[i], got, exps[i]);
      end
      data = 32'd0;
    end
  endtask

  task automatic test_shift_merge;
    @(negedge clock);
    bus.Headers_Shift_1_En_I = 1;
    #1;
    checks++; if ({shift1, shift8} !== 2'b10) begin fails++; $display("[TB] FAIL merge_hdr_s1 got=%b exp=10", {shift1, shift8}); end
    bus.Headers_Shift_1_En_I = 0; bus.Picture_Shift_8_En_I = 1;
    #1;
    checks++; if ({shift1, shift8} !== 2'b01) begin fails++; $display("[TB] FAIL merge_pic_s8 got=%b exp=01", {shift1, shift8}); end
    bus.Picture_Shift_8_En_I = 0; bus.Picture_Shift_1_En_I = 1; bus.Headers_Shift_8_En_I = 1;
    #1;
    checks++; if ({shift1, shift8} !== 2'b11) begin fails++; $display("[TB] FAIL merge_both got=%b exp=11", {shift1, shift8}); end
    bus.Picture_Shift_1_En_I = 0; bus.Headers_Shift_8_En_I = 0;
  endtask

  task automatic test_advance;
    bus.Headers_Done_I = 1; picAuto = 0; picDone = 0;
    @(negedge clock) adv = 1;
    @(negedge clock) adv = 0;
    waitState(S_HDR, 5);
    checks++; if (bus.Headers_Start_O !== 1'b1) begin fails++; $display("[TB] FAIL hdr_start_pulse got=%b exp=1", bus.Headers_Start_O); end
    waitState(S_RUN, 5);
    checks++; if (bus.Picture_Start_O !== 1'b1) begin fails++; $display("[TB] FAIL pic_start_raise got=%b exp=1", bus.Picture_Start_O); end
    @(negedge clock) adv = 1;
    @(negedge clock) adv = 0;
    @(negedge clock) adv = 1;
    @(negedge clock) adv = 0;
    checks++; if (bus.Picture_Start_O !== 1'b0) begin fails++; $display("[TB] FAIL pic_start_drop got=%b exp=0", bus.Picture_Start_O); end
    picDone = 1;
    waitState(S_WAIT, 5);
    picDone = 0;
    checks++; if (picCount !== 16'd1) begin fails++; $display("[TB] FAIL adv_count1 got=%0d exp=1", picCount); end
    waitState(S_RUN, 8);
    @(negedge clock);
    @(negedge clock) picDone = 1;
    waitState(S_WAIT, 5);
    picDone = 0;
    checks++; if (picCount !== 16'd2) begin fails++; $display("[TB] FAIL adv_count2 got=%0d exp=2", picCount); end
    repeat (5) @(negedge clock);
    checks++; if (state !== S_WAIT || picCount !== 16'd2) begin
      fails++; $display("[TB] FAIL adv_extra_dropped state=%0d count=%0d exp state=%0d count=2", state, picCount, S_WAIT);
    end
  endtask

  // Each free-running picture takes 5 cycles: WAIT_ADV, two HEADERS, two RUN.
  task automatic test_free_run;
    int at = -1;
    @(negedge clock) start = 1;
    @(negedge clock) start = 0;
    waitState(S_WAIT, 50);
    checks++; if (state !== S_WAIT || picCount !== 16'd0) begin
      fails++; $display("[TB] FAIL restart_clear state=%0d count=%0d exp state=%0d count=0", state, picCount, S_WAIT);
    end
    picAuto = 1; freeRun = 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (picCount === 16'd3) begin freeRun = 0; at = n; break; end
    end
    checks++; if (at != 15) begin fails++; $display("[TB] FAIL free_run_cycles got=%0d exp=15", at); end
    repeat (6) @(negedge clock);
    checks++; if (picCount !== 16'd3 || state !== S_WAIT) begin
      fails++; $display("[TB] FAIL free_run_stop count=%0d state=%0d exp count=3 state=%0d", picCount, state, S_WAIT);
    end
    picAuto = 0;
  endtask

  task automatic test_seq_end;
    @(negedge clock) adv = 1;
    @(negedge clock) begin adv = 0; data = 32'h000001B7; end
    @(negedge clock);
    checks++; if (state !== S_IDLE || seqEnd !== 1'b1 || bus.Headers_Start_O !== 1'b0) begin
      fails++; $display("[TB] FAIL seq_end_pulse state=%0d end=%b hs=%b exp state=0 end=1 hs=0", state, seqEnd, bus.Headers_Start_O);
    end
    data = 32'd0;
    @(negedge clock);
    checks++; if (state !== S_IDLE || seqEnd !== 1'b0 || bus.Headers_Start_O !== 1'b0) begin
      fails++; $display("[TB] FAIL seq_end_once state=%0d end=%b hs=%b exp state=0 end=0 hs=0", state, seqEnd, bus.Headers_Start_O);
    end
    checks++; if (errFlag !== 1'b0) begin fails++; $display("[TB] FAIL error_quiet got=%b exp=0", errFlag); end
  endtask

`ifdef SEQUENCE_CONTROL_TIMEOUT_EN
  task automatic test_timeout;
    int runCycles = 1;
    @(negedge clock) start = 1;
    @(negedge clock) start = 0;
    waitState(S_WAIT, 50);
    bus.Headers_Done_I = 1; picAuto = 0; picDone = 0; freeRun = 1;
    waitState(S_HDR, 5);
    freeRun = 0;
    waitState(S_RUN, 5);
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (state !== S_RUN) break;
      runCycles++;
    end
    checks++; if (runCycles != 16) begin fails++; $display("[TB] FAIL wdog_run_cycles got=%0d exp=16", runCycles); end
    checks++; if (errFlag !== 1'b1 || state !== S_ERR || bus.Picture_Start_O !== 1'b0) begin
      fails++; $display("[TB] FAIL wdog_error err=%b state=%0d ps=%b exp err=1 state=6 ps=0", errFlag, state, bus.Picture_Start_O);
    end
    @(negedge clock) start = 1;
    @(negedge clock) start = 0;
    checks++; if (errFlag !== 1'b0 || state !== S_RESET) begin
      fails++; $display("[TB] FAIL wdog_clear err=%b state=%0d exp err=0 state=1", errFlag, state);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_classify();
    test_shift_merge();
    test_advance();
    test_free_run();
    test_seq_end();
`ifdef SEQUENCE_CONTROL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
